// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: 4-deep host command FIFO feeding an LCD controller, with image load and result capture.
// Optional watchdog on WAIT/FINISH is enabled by defining LCD_CMD_SCHED_WDOG_EN.
module lcd_cmd_sched (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] host_cmd,
  input  logic       host_push,
  output logic       host_full,
  output logic       host_ovf,
  output logic       host_err,
  output logic [5:0] img_addr,
  input  logic [7:0] img_data,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic       lcd_output_valid,
  input  logic [7:0] lcd_dataout,
  output logic [7:0] pix_out,
  output logic       pix_valid,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0] state_q, state_d;
  logic [2:0] fifo_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       ovf_q;
  logic [5:0] addr_q, addr_d;
  logic [3:0] ovc_q, ovc_d;
  logic [7:0] pix_out_q;
  logic       pix_valid_q;
  logic [2:0] head;
  logic       head_bad;
  logic       push_ok;
  logic       pop;
  logic       wdog_to;

  assign head      = fifo_q[rd_ptr_q];
  assign head_bad  = head[2] & head[1];
  assign host_full = (count_q == 3'd4);
  // Invalid heads are discarded regardless of busy; valid ones wait for the controller.
  assign pop       = (state_q == S_ISSUE) && (head_bad || !lcd_busy);
  assign push_ok   = host_push && (!host_full || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
      if (host_push && host_full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= host_cmd;
  end

`ifdef LCD_CMD_SCHED_WDOG_EN
  logic [7:0] wdog_q;
  logic       in_wait;

  assign in_wait = (state_q == S_WAIT) || (state_q == S_FINISH);
  // wdog_q == 254 marks the 255th consecutive cycle spent in WAIT/FINISH.
  assign wdog_to = in_wait && (wdog_q == 8'd254);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   wdog_q <= 8'd0;
    else if (in_wait && !wdog_to) wdog_q <= wdog_q + 8'd1;
    else                          wdog_q <= 8'd0;
  end
`else
  assign wdog_to = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ovc_d   = ovc_q;
    case (state_q)
      S_IDLE: if (count_q != 3'd0 && !lcd_busy) state_d = S_ISSUE;
      S_ISSUE: begin
        if (head_bad) begin
          state_d = S_IDLE;
        end else if (!lcd_busy) begin
          state_d = (head == 3'd1) ? S_LOAD : S_WAIT;
          addr_d  = 6'd0;
          ovc_d   = 4'd0;
        end
      end
      S_LOAD: begin
        if (addr_q == 6'd35) begin
          state_d = S_WAIT;
          ovc_d   = 4'd0;
        end else begin
          addr_d = addr_q + 6'd1;
        end
      end
      S_WAIT: begin
        if (lcd_output_valid) begin
          if (ovc_q == 4'd8) state_d = S_FINISH;
          else               ovc_d   = ovc_q + 4'd1;
        end
      end
      S_FINISH: if (!lcd_busy) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (wdog_to) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= 6'd0;
      ovc_q       <= 4'd0;
      pix_out_q   <= 8'd0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ovc_q       <= ovc_d;
      pix_valid_q <= lcd_output_valid;
      if (lcd_output_valid) pix_out_q <= lcd_dataout;
    end
  end

  assign host_ovf      = ovf_q;
  assign host_err      = ((state_q == S_ISSUE) && head_bad) || wdog_to;
  assign lcd_cmd_valid = (state_q == S_ISSUE) && !head_bad && !lcd_busy;
  assign lcd_cmd       = lcd_cmd_valid ? head : 3'd0;
  assign img_addr      = (state_q == S_LOAD) ? addr_q : 6'd0;
  assign lcd_datain    = (state_q == S_LOAD) ? img_data : 8'd0;
  assign pix_out       = pix_out_q;
  assign pix_valid     = pix_valid_q;
  assign done          = (state_q == S_FINISH) && !lcd_busy && !wdog_to;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed testbench for lcd_cmd_sched with a small behavioural LCD controller model.
module tb_lcd_cmd_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] host_cmd = 3'd0;
  logic       host_push = 1'b0;
  logic       host_full, host_ovf, host_err;
  logic [5:0] img_addr;
  logic [7:0] img_data;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       lcd_busy;
  logic       lcd_output_valid;
  logic [7:0] lcd_dataout;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic       done;

  logic       tb_busy = 1'b0;
  logic       model_en = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovalid = 1'b0;
  logic [7:0] m_dout = 8'd0;
  logic [2:0] m_cmd = 3'd0;

  int n_tests = 0;
  int n_fail = 0;
  int n_issue = 0;
  int n_done = 0;
  int n_pix = 0;
  int n_err = 0;
  int n_busy_viol = 0;
  logic [7:0] last_pix = 8'd0;
  logic [2:0] issued_q[$];

  assign img_data         = {2'b00, img_addr};
  assign lcd_busy         = m_busy | tb_busy;
  assign lcd_output_valid = m_ovalid;
  assign lcd_dataout      = m_dout;

  always #5 clk = ~clk;

  lcd_cmd_sched dut (
    .clk(clk), .reset(reset),
    .host_cmd(host_cmd), .host_push(host_push),
    .host_full(host_full), .host_ovf(host_ovf), .host_err(host_err),
    .img_addr(img_addr), .img_data(img_data),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_busy(lcd_busy), .lcd_output_valid(lcd_output_valid), .lcd_dataout(lcd_dataout),
    .pix_out(pix_out), .pix_valid(pix_valid), .done(done)
  );

  // LCD model: busy after accepting a command, 36 load cycles for LOAD, then 9 results.
  initial begin
    forever begin
      @(negedge clk);
      if (lcd_cmd_valid && model_en) begin
        m_cmd = lcd_cmd;
        @(posedge clk); #1 m_busy = 1'b1;
        if (m_cmd == 3'd1) repeat (36) @(posedge clk);
        for (int k = 0; k < 9; k++) begin
          @(posedge clk); #1;
          m_ovalid = 1'b1;
          m_dout   = 8'hA0 + 8'(k);
        end
        @(posedge clk); #1 m_ovalid = 1'b0;
        @(posedge clk); #1 m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (lcd_cmd_valid) begin
      n_issue = n_issue + 1;
      issued_q.push_back(lcd_cmd);
      if (lcd_busy) n_busy_viol = n_busy_viol + 1;
    end
    if (done) n_done = n_done + 1;
    if (host_err) n_err = n_err + 1;
    if (pix_valid) begin
      n_pix = n_pix + 1;
      last_pix = pix_out;
    end
  end

  task automatic push(input logic [2:0] c);
    host_cmd  = c;
    host_push = 1'b1;
    @(negedge clk);
    host_push = 1'b0;
    $display("[TB] push cmd=%0d full=%0b ovf=%0b", c, host_full, host_ovf);
  endtask

  task automatic wait_done(input int target, input int budget, output bit timed_out);
    int b;
    b = budget;
    while (n_done < target && b > 0) begin
      @(negedge clk);
      b = b - 1;
    end
    timed_out = (n_done < target);
  endtask

  task automatic wait_issue(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (lcd_cmd_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({host_full, host_ovf, host_err, lcd_cmd_valid, done, pix_valid} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000000",
               {host_full, host_ovf, host_err, lcd_cmd_valid, done, pix_valid});
    end
    n_tests++;
    if ({lcd_cmd, img_addr, lcd_datain, pix_out} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_buses got cmd=%0d addr=%0d din=%0d pix=%0d want 0",
               lcd_cmd, img_addr, lcd_datain, pix_out);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({host_full, lcd_cmd_valid, n_issue} !== {2'b00, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_release got full=%0b valid=%0b issues=%0d want 0", host_full, lcd_cmd_valid, n_issue);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_load;
    int d0, p0, i0;
    bit seen, to;
    d0 = n_done; p0 = n_pix; i0 = n_issue;
    push(3'd1);
    wait_issue(10, seen);
    n_tests++;
    if (!seen || lcd_cmd !== 3'd1) begin
      n_fail++;
      $display("FAIL load_issue got seen=%0b cmd=%0d want seen=1 cmd=1", seen, lcd_cmd);
    end
    @(negedge clk);
    for (int i = 0; i < 36; i++) begin
      n_tests++;
      if (img_addr !== 6'(i) || lcd_datain !== 8'(i)) begin
        n_fail++;
        $display("FAIL load_addr[%0d] got addr=%0d din=%0d want %0d", i, img_addr, lcd_datain, i);
      end
      @(negedge clk);
    end
    n_tests++;
    if (img_addr !== 6'd0 || lcd_datain !== 8'd0) begin
      n_fail++;
      $display("FAIL load_after got addr=%0d din=%0d want 0", img_addr, lcd_datain);
    end
    wait_done(d0 + 1, 200, to);
    repeat (3) @(negedge clk);
    n_tests++;
    if (to || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL load_done got %0d want 1", n_done - d0);
    end
    n_tests++;
    if (n_pix - p0 != 9 || last_pix !== 8'hA8) begin
      n_fail++;
      $display("FAIL load_pix got count=%0d last=%h want 9 a8", n_pix - p0, last_pix);
    end
    n_tests++;
    if (n_issue - i0 != 1) begin
      n_fail++;
      $display("FAIL load_issue_count got %0d want 1", n_issue - i0);
    end
    $display("[TB] test_load done");
  endtask

  task automatic test_back_to_back;
    int d0, i0;
    bit to;
    logic [2:0] exp_seq [4];
    exp_seq[0] = 3'd2; exp_seq[1] = 3'd3; exp_seq[2] = 3'd4; exp_seq[3] = 3'd5;
    d0 = n_done; i0 = n_issue;
    tb_busy = 1'b1;
    push(3'd2); push(3'd3); push(3'd4); push(3'd5);
    n_tests++;
    if (host_full !== 1'b1 || host_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full got full=%0b ovf=%0b want 1 0", host_full, host_ovf);
    end
    push(3'd0);
    n_tests++;
    if (host_full !== 1'b1 || host_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ovf got full=%0b ovf=%0b want 1 1", host_full, host_ovf);
    end
    n_tests++;
    if (n_issue != i0) begin
      n_fail++;
      $display("FAIL b2b_busy_hold got %0d issues want 0", n_issue - i0);
    end
    tb_busy = 1'b0;
    wait_done(d0 + 4, 600, to);
    repeat (10) @(negedge clk);
    n_tests++;
    if (to || n_issue - i0 != 4) begin
      n_fail++;
      $display("FAIL b2b_count got issues=%0d dones=%0d want 4 4", n_issue - i0, n_done - d0);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (i0 + k >= issued_q.size() || issued_q[i0 + k] !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL b2b_order[%0d] got %0d want %0d", k,
                 (i0 + k < issued_q.size()) ? issued_q[i0 + k] : 3'd0, exp_seq[k]);
      end
    end
    n_tests++;
    if (n_busy_viol != 0 || host_full !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy_viol got viol=%0d full=%0b want 0 0", n_busy_viol, host_full);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_err;
    int e0, i0, d0;
    bit seen, to;
    e0 = n_err; i0 = n_issue; d0 = n_done;
    push(3'd7);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (host_err) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++;
    if (!seen || lcd_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse got err=%0b valid=%0b want 1 0", seen, lcd_cmd_valid);
    end
    push(3'd4);
    n_tests++;
    if (host_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_width got %0b want 0", host_err);
    end
    @(negedge clk);
    n_tests++;
    if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 3'd4) begin
      n_fail++;
      $display("FAIL err_idle_next got valid=%0b cmd=%0d want 1 4", lcd_cmd_valid, lcd_cmd);
    end
    wait_done(d0 + 1, 200, to);
    n_tests++;
    if (to || n_err - e0 != 1 || n_issue - i0 != 1) begin
      n_fail++;
      $display("FAIL err_counts got err=%0d issues=%0d want 1 1", n_err - e0, n_issue - i0);
    end
    $display("[TB] test_err done");
  endtask

  task automatic test_busy_hold;
    int i0, d0;
    bit to;
    i0 = n_issue; d0 = n_done;
    tb_busy = 1'b1;
    push(3'd3);
    repeat (10) @(negedge clk);
    n_tests++;
    if (n_issue != i0) begin
      n_fail++;
      $display("FAIL busy_hold got %0d issues want 0", n_issue - i0);
    end
    tb_busy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 3'd3) begin
      n_fail++;
      $display("FAIL busy_drop got valid=%0b cmd=%0d want 1 3", lcd_cmd_valid, lcd_cmd);
    end
    wait_done(d0 + 1, 200, to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL busy_done got timeout want done");
    end
    $display("[TB] test_busy_hold done");
  endtask

  task automatic test_reset_mid_load;
    int d0, i0;
    bit seen, at20;
    d0 = n_done;
    push(3'd1);
    wait_issue(10, seen);
    at20 = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (img_addr == 6'd20) begin
        at20 = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen || !at20) begin
      n_fail++;
      $display("FAIL rst_load_reach got issue=%0b addr20=%0b want 1 1", seen, at20);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({host_full, host_ovf, host_err, lcd_cmd_valid, done, pix_valid} !== 6'd0 ||
        {lcd_cmd, img_addr, lcd_datain, pix_out} !== 25'd0) begin
      n_fail++;
      $display("FAIL rst_load_outputs got flags=%b cmd=%0d addr=%0d din=%0d pix=%0d want 0",
               {host_full, host_ovf, host_err, lcd_cmd_valid, done, pix_valid},
               lcd_cmd, img_addr, lcd_datain, pix_out);
    end
    @(negedge clk);
    reset = 1'b1;
    i0 = n_issue;
    repeat (80) @(negedge clk);
    n_tests++;
    if (n_done != d0 || n_issue != i0 || host_full !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_load_after got dones=%0d issues=%0d want 0 0", n_done - d0, n_issue - i0);
    end
    $display("[TB] test_reset_mid_load done");
  endtask

`ifdef LCD_CMD_SCHED_WDOG_EN
  task automatic test_wdog;
    int d0, e0, k;
    bit seen;
    d0 = n_done; e0 = n_err;
    model_en = 1'b0;
    push(3'd2);
    wait_issue(10, seen);
    k = 0;
    while (k < 400 && !host_err) begin
      @(negedge clk);
      k = k + 1;
    end
    n_tests++;
    if (!seen || k != 255) begin
      n_fail++;
      $display("FAIL wdog_time got %0d cycles want 255", k);
    end
    @(negedge clk);
    n_tests++;
    if (host_err !== 1'b0 || n_done != d0 || n_err - e0 != 1) begin
      n_fail++;
      $display("FAIL wdog_after got err=%0b dones=%0d errs=%0d want 0 0 1", host_err, n_done - d0, n_err - e0);
    end
    model_en = 1'b1;
    $display("[TB] test_wdog done");
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_err();
    test_busy_hold();
    test_reset_mid_load();
`ifdef LCD_CMD_SCHED_WDOG_EN
    test_wdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
